// File: rtl/atk16_mem_pkg.sv
// Shared definitions for the SRAM arbiter slice.
//   - arb_state_t : access sequencer states
//   - PORT_CU / PORT_AUX : requester indices (control unit, auxiliary master)
//   - DEF_ADDR_W / DEF_DATA_W : default SRAM word address and data widths
//   - gnt_idx() : converts a one-hot two-port grant into a port index
package atk16_mem_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 16;

  // Width of the ACCESS down-counter; supports ACCESS_CYCLES of 1..15.
  localparam int unsigned CNT_W = 4;

  localparam logic PORT_CU  = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  // One-hot grant {aux, cu} to port index; only meaningful when a grant is present.
  function automatic logic gnt_idx(input logic [1:0] gnt);
    return gnt[1];
  endfunction

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_req      : request vector {aux, cu}
//   i_update   : commit the current grant into the last-grant history
//   o_gnt      : one-hot grant (combinational from i_req and history)
// After reset the history points at port 1, so port 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic [1:0] o_gnt
);

  logic r_last_gnt;

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      // Tie: the port that was not served last time wins.
      2'b11:   o_gnt = r_last_gnt ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt <= 1'b1;
    end else if (i_update && (|o_gnt)) begin
      r_last_gnt <= o_gnt[1];
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master arbiter and access sequencer for a single asynchronous SRAM.
// Each access runs IDLE -> SETUP -> ACCESS (ACCESS_CYCLES) -> DONE -> IDLE,
// so one access occupies ACCESS_CYCLES+3 cycles and the ack pulse lands in
// cycle ACCESS_CYCLES+2 counted from the IDLE cycle that sampled the request.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   m0_* / m1_*               : master ports (req/we/addr/wdata in, rdata/ack out)
//                               port 0 = control unit, port 1 = auxiliary master
//   sram_cs_n/oe_n/we_n       : SRAM strobes, active low, registered
//   sram_addr, sram_dq_out    : SRAM address and write data, registered
//   sram_dq_in                : read data from the pads
//   sram_dq_oe                : pad output enable (1 = drive SD)
//   busy                      : high whenever the sequencer is not in IDLE
// ACCESS_CYCLES must be in 1..15.
module sram_arbiter
  import atk16_mem_pkg::*;
#(
  parameter int unsigned ADDR_W        = DEF_ADDR_W,
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,

  output logic              sram_cs_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  arb_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_port;
  logic              r_we;
  logic              r_cs_n;
  logic              r_oe_n;
  logic              r_we_n;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dq_out;
  logic              r_dq_oe;
  logic              r_ack0;
  logic              r_ack1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_busy;

  logic [1:0]        w_gnt;
  logic              w_update;
  logic              w_sel_aux;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Requests are only looked at in IDLE; the history advances on each grant taken there.
  assign w_update = (r_state == IDLE);

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    ({m1_req, m0_req}),
    .i_update (w_update),
    .o_gnt    (w_gnt)
  );

  assign w_sel_aux   = gnt_idx(w_gnt);
  assign w_sel_we    = w_sel_aux ? m1_we    : m0_we;
  assign w_sel_addr  = w_sel_aux ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_sel_aux ? m1_wdata : m0_wdata;

  // Every pin-facing value below is a flop output; the strobe pattern for a
  // state is loaded on the edge that enters it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_port   <= PORT_CU;
      r_we     <= 1'b0;
      r_cs_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_we_n   <= 1'b1;
      r_addr   <= '0;
      r_dq_out <= '0;
      r_dq_oe  <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ack0 <= 1'b0;
          r_ack1 <= 1'b0;
          if (|w_gnt) begin
            r_port  <= w_sel_aux;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_cs_n  <= 1'b0;
            r_dq_oe <= w_sel_we;
            r_busy  <= 1'b1;
            if (w_sel_we) begin
              r_dq_out <= w_sel_wdata;
            end
            r_state <= SETUP;
          end
        end

        SETUP: begin
          r_oe_n  <= r_we;
          r_we_n  <= ~r_we;
          r_cnt   <= CNT_LAST;
          r_state <= ACCESS;
        end

        ACCESS: begin
          if (r_cnt == '0) begin
            r_oe_n <= 1'b1;
            r_we_n <= 1'b1;
            if (!r_we) begin
              if (r_port == PORT_AUX) begin
                r_rdata1 <= sram_dq_in;
              end else begin
                r_rdata0 <= sram_dq_in;
              end
            end
            r_ack0  <= (r_port == PORT_CU);
            r_ack1  <= (r_port == PORT_AUX);
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        DONE: begin
          // Address and write data stay put through DONE for write hold time.
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_cs_n  <= 1'b1;
          r_dq_oe <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign sram_cs_n   = r_cs_n;
  assign sram_oe_n   = r_oe_n;
  assign sram_we_n   = r_we_n;
  assign sram_addr   = r_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_dq_oe;
  assign m0_ack      = r_ack0;
  assign m1_ack      = r_ack1;
  assign m0_rdata    = r_rdata0;
  assign m1_rdata    = r_rdata1;
  assign busy        = r_busy;

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
module tb_sram_arbiter;

  localparam int AC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [15:0] m0_addr = '0, m0_wdata = '0;
  logic [15:0] m0_rdata;
  logic        m0_ack;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [15:0] m1_addr = '0, m1_wdata = '0;
  logic [15:0] m1_rdata;
  logic        m1_ack;
  logic        sram_cs_n, sram_oe_n, sram_we_n, sram_dq_oe, busy;
  logic [15:0] sram_addr, sram_dq_out, sram_dq_in;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct { logic we; logic [15:0] data; } sb_t;
  sb_t q0[$];
  sb_t q1[$];

  typedef struct { logic port; logic we; logic [15:0] addr; logic [15:0] data; } vec_t;
  vec_t tbl[8];

  logic [15:0] sram_mem [65536];

  sram_arbiter #(.ADDR_W(16), .DATA_W(16), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_addr(sram_addr), .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Asynchronous SRAM: reads are combinational while selected and output-enabled.
  assign sram_dq_in = (!sram_cs_n && !sram_oe_n) ? sram_mem[sram_addr] : 16'h0BAD;
  always @(negedge clk) begin
    if (!sram_cs_n && !sram_we_n)
      sram_mem[sram_addr] <= sram_dq_oe ? sram_dq_out : 16'hDEAD;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic port, input logic we, input logic [15:0] a, input logic [15:0] d);
    if (port) begin m1_we = we; m1_addr = a; m1_wdata = d; m1_req = 1'b1; end
    else      begin m0_we = we; m0_addr = a; m0_wdata = d; m0_req = 1'b1; end
  endtask

  task automatic set_req(input logic port, input logic v);
    if (port) m1_req = v; else m0_req = v;
  endtask

  task automatic push(input logic port, input logic we, input logic [15:0] d);
    sb_t e;
    e.we = we; e.data = d;
    if (port) q1.push_back(e); else q0.push_back(e);
  endtask

  // Scoreboard and pin-level protocol monitor.
  always @(negedge clk) begin
    sb_t e;
    if (rst_n) begin
      chk("oe_we_excl", {31'b0, !(!sram_oe_n && !sram_we_n)}, 1);
      chk("dqoe_oe_excl", {31'b0, !(sram_dq_oe && !sram_oe_n)}, 1);
      chk("ack_onehot", {31'b0, !(m0_ack && m1_ack)}, 1);
      if (m0_ack) begin
        if (q0.size() == 0) chk("m0_unexpected_ack", 1, 0);
        else begin
          e = q0.pop_front();
          if (!e.we) chk("m0_rdata", m0_rdata, e.data);
        end
      end
      if (m1_ack) begin
        if (q1.size() == 0) chk("m1_unexpected_ack", 1, 0);
        else begin
          e = q1.pop_front();
          if (!e.we) chk("m1_rdata", m1_rdata, e.data);
        end
      end
    end
  end

  task automatic port_traffic(input logic port);
    logic [15:0] sh [16];
    logic [15:0] base, d;
    logic [3:0]  idx;
    logic        we, got;
    base = port ? 16'h2000 : 16'h1000;
    for (int n = 0; n < 56; n++) begin
      if (n < 16) begin we = 1'b1; idx = 4'(n); end
      else begin we = 1'($urandom_range(0, 1)); idx = 4'($urandom_range(0, 15)); end
      d = 16'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(posedge clk); #1;
      drive(port, we, base | {12'b0, idx}, d);
      if (we) begin sh[idx] = d; push(port, 1'b1, d); end
      else push(port, 1'b0, sh[idx]);
      got = 1'b0;
      for (int t = 0; t < 40; t++) begin
        @(negedge clk);
        if (port ? m1_ack : m0_ack) begin got = 1'b1; break; end
      end
      if (port) chk("m1_rand_ack", {31'b0, got}, 1);
      else      chk("m0_rand_ack", {31'b0, got}, 1);
      set_req(port, 1'b0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        got, prt;
    logic [15:0] other_rd;
    int          last;

    tbl[0] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF};
    tbl[1] = '{1'b1, 1'b0, 16'h0010, 16'hBEEF};
    tbl[2] = '{1'b1, 1'b1, 16'h0200, 16'h1234};
    tbl[3] = '{1'b0, 1'b0, 16'h0200, 16'h1234};
    tbl[4] = '{1'b0, 1'b1, 16'hFFFF, 16'hA5A5};
    tbl[5] = '{1'b1, 1'b0, 16'hFFFF, 16'hA5A5};
    tbl[6] = '{1'b1, 1'b1, 16'h0000, 16'hFFFF};
    tbl[7] = '{1'b0, 1'b0, 16'h0000, 16'hFFFF};

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cs_n", {31'b0, sram_cs_n}, 1);
    chk("rst_oe_n", {31'b0, sram_oe_n}, 1);
    chk("rst_we_n", {31'b0, sram_we_n}, 1);
    chk("rst_addr", {16'b0, sram_addr}, 0);
    chk("rst_dq_out", {16'b0, sram_dq_out}, 0);
    chk("rst_dq_oe", {31'b0, sram_dq_oe}, 0);
    chk("rst_acks", {30'b0, m1_ack, m0_ack}, 0);
    chk("rst_rdata", {m1_rdata, m0_rdata}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Idle with no requests
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_strobes", {28'b0, sram_cs_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
      chk("idle_busy", {31'b0, busy}, 0);
    end

    // Single-port accesses with cycle-level strobe timing
    for (int i = 0; i < 8; i++) begin
      logic own_ack, oth_ack, act, acc;
      @(posedge clk); #1;
      drive(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].data);
      push(tbl[i].port, tbl[i].we, tbl[i].data);
      other_rd = tbl[i].port ? m0_rdata : m1_rdata;
      for (int c = 0; c <= AC + 3; c++) begin
        @(negedge clk);
        act = (c >= 1 && c <= AC + 2);
        acc = (c >= 2 && c <= AC + 1);
        own_ack = tbl[i].port ? m1_ack : m0_ack;
        oth_ack = tbl[i].port ? m0_ack : m1_ack;
        chk("vec_cs_n", {31'b0, sram_cs_n}, {31'b0, !act});
        chk("vec_we_n", {31'b0, sram_we_n}, {31'b0, !(acc && tbl[i].we)});
        chk("vec_oe_n", {31'b0, sram_oe_n}, {31'b0, !(acc && !tbl[i].we)});
        chk("vec_dq_oe", {31'b0, sram_dq_oe}, {31'b0, act && tbl[i].we});
        chk("vec_busy", {31'b0, busy}, {31'b0, act});
        chk("vec_own_ack", {31'b0, own_ack}, {31'b0, c == AC + 2});
        chk("vec_other_ack", {31'b0, oth_ack}, 0);
        chk("vec_other_rdata", {16'b0, tbl[i].port ? m0_rdata : m1_rdata}, {16'b0, other_rd});
        if (act) chk("vec_addr", {16'b0, sram_addr}, {16'b0, tbl[i].addr});
        if (act && tbl[i].we) chk("vec_dq_out", {16'b0, sram_dq_out}, {16'b0, tbl[i].data});
        if (c == AC + 2) set_req(tbl[i].port, 1'b0);
      end
    end

    // Both ports requesting continuously from reset: strict alternation
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    drive(1'b0, 1'b0, 16'h0010, 16'h0);
    drive(1'b1, 1'b0, 16'h0200, 16'h0);
    for (int k = 0; k < 50; k++) begin
      push(1'b0, 1'b0, 16'hBEEF);
      push(1'b1, 1'b0, 16'h1234);
    end
    last = 0;
    for (int k = 0; k < 100; k++) begin
      got = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (m0_ack || m1_ack) begin got = 1'b1; break; end
      end
      chk("cont_ack_seen", {31'b0, got}, 1);
      if (!got) begin
        m0_req = 1'b0; m1_req = 1'b0;
        break;
      end
      chk("cont_grant_order", {31'b0, m1_ack}, k % 2);
      if (k > 0) chk("cont_ack_spacing", cyc - last, AC + 3);
      last = cyc;
      if (k == 99) begin m0_req = 1'b0; m1_req = 1'b0; end
    end
    repeat (AC + 4) @(negedge clk);
    q0.delete(); q1.delete();

    // Reset during the ACCESS phase of a write
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 16'h0300, 16'h5555);
    repeat (3) @(negedge clk);
    chk("abort_we_low", {31'b0, sram_we_n}, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we_n", {31'b0, sram_we_n}, 1);
    chk("abort_cs_n", {31'b0, sram_cs_n}, 1);
    chk("abort_dq_oe", {31'b0, sram_dq_oe}, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    m0_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_no_ack", {30'b0, m1_ack, m0_ack}, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 16'h0400, 16'h1111);
    drive(1'b1, 1'b1, 16'h0500, 16'h2222);
    push(1'b0, 1'b1, 16'h1111);
    push(1'b1, 1'b1, 16'h2222);
    for (int n = 0; n < 2; n++) begin
      got = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (m0_ack || m1_ack) begin got = 1'b1; break; end
      end
      chk("post_rst_ack_seen", {31'b0, got}, 1);
      prt = m1_ack;
      chk("post_rst_grant", {31'b0, prt}, n);
      set_req(prt, 1'b0);
    end
    repeat (AC + 4) @(negedge clk);

    // Random traffic on both ports, disjoint address windows
    fork
      port_traffic(1'b0);
      port_traffic(1'b1);
    join
    repeat (10) @(negedge clk);
    chk("sb_q0_empty", q0.size(), 0);
    chk("sb_q1_empty", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
